pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning PC/target width (minimum 8).
REQ-002 The block SHALL have parameter RESET_VEC, default 32'h0040_0000, meaning the PC value after reset.
REQ-003 The block SHALL have parameter EXC_VEC, default 32'h0040_0004, meaning the trap entry address.
REQ-004 The block SHALL have parameter STEP, default 4, meaning the sequential increment in bytes.
REQ-005 Port clk, input, 1 bit: the single clock; all state SHALL update on its falling edge.
REQ-006 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-007 Port ena, input, 1 bit: advance enable; low SHALL hold all state (stall).
REQ-008 Port br_taken, input, 1 bit: conditional branch taken.
REQ-009 Port br_off, input, 16 bits: word offset, sign-extended and shifted left 2.
REQ-010 Port jmp, input, 1 bit: absolute jump.
REQ-011 Port jmp_idx, input, 26 bits: jump index.
REQ-012 Port jr, input, 1 bit: register jump.
REQ-013 Port jr_addr, input, XLEN bits: register jump target.
REQ-014 Port exc_req, input, 1 bit: external exception request.
REQ-015 Port exc_code, input, 5 bits: cause code for exc_req.
REQ-016 Port eret, input, 1 bit: return from exception.
REQ-017 Port pc, output, XLEN bits: current PC.
REQ-018 Port pc_plus, output, XLEN bits: pc + STEP.
REQ-019 Port epc, output, XLEN bits: saved exception PC.
REQ-020 Port cause, output, 5 bits: latched cause code.
REQ-021 Port exl, output, 1 bit: exception-level flag.

Function
REQ-022 The next PC SHALL be selected with fixed priority: exception > eret > jr > jmp > branch > sequential.
REQ-023 Sequential next PC SHALL be pc + STEP, modulo 2^XLEN, wrapping from all-ones to low addresses without a flag.
REQ-024 Branch target SHALL be pc_plus + (sext(br_off) << 2), modulo 2^XLEN.
REQ-025 Jump target SHALL be {pc_plus[XLEN-1:28], jmp_idx, 2'b00}.
REQ-026 A jr target with jr_addr[1:0] != 0 SHALL raise an internal address-error exception, with cause ADEL = 5'd4, instead of jumping.
REQ-027 exc_req SHALL take priority over an internal address error; cause SHALL be taken from exc_code.
REQ-028 On an exception with exl=0, the block SHALL load pc into epc, load cause, set exl=1, and set next PC to EXC_VEC.
REQ-029 On an exception with exl=1 (nested), the block SHALL go to EXC_VEC and update cause, while epc SHALL be preserved.
REQ-030 eret with exl=1 SHALL set next PC to epc and clear exl.
REQ-031 eret with exl=0 SHALL act as a sequential step with no other effect.
REQ-032 Simultaneous eret and exception SHALL be treated as exception only.
REQ-033 With ena=0, pc, epc, cause and exl SHALL hold, and all requests that cycle SHALL be ignored.
REQ-034 Outputs SHALL be registered state; the update latency SHALL be one clk falling edge after the inputs are sampled.
REQ-035 pc_plus SHALL be combinational from pc.

Reset
REQ-036 While rst_n=0, asynchronously: pc=RESET_VEC, epc=0, cause=0, exl=0.
REQ-037 While rst_n=0, the pc output SHALL read RESET_VEC regardless of clock, independently of ena.
REQ-038 Reset asserted mid-exception or mid-stall SHALL override all state.
REQ-039 On release, the first advance SHALL occur at the first falling edge with ena=1.

Structure
REQ-040 Package pc_pkg SHALL hold the cause codes (ADEL=4), the next-PC select enum {SEQ, BR, JMP, JR, ERET, EXC}, and the default vectors.
REQ-041 Sub-module pc_next_sel SHALL be purely combinational, computing the select and the target; state SHALL live only in pc_unit.

Verification
REQ-042 Reset release, ena=1, no requests: pc SHALL read 0x00400000, then 0x00400004, then 0x00400008 on successive falling edges.
REQ-043 pc=0x00400010, br_taken=1, br_off=16'hFFFF: next pc SHALL be 0x00400010; with jmp=1 also asserted, pc SHALL be the jump target.
REQ-044 jr=1, jr_addr=0x00400102: pc SHALL be 0x00400004, epc SHALL be the faulting pc, cause SHALL be 4, exl SHALL be 1; then eret SHALL restore epc and exl SHALL be 0.
REQ-045 Nested exc_req (code 8) while exl=1: pc SHALL be EXC_VEC, cause SHALL be 8, and epc SHALL be unchanged.
REQ-046 ena=0 held 3 cycles with jmp=1: pc SHALL be unchanged; asserting rst_n=0 mid-stall SHALL force pc to 0x00400000 immediately.
REQ-047 XLEN=16, pc=0xFFFC: next sequential pc SHALL be 0x0000.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter unit.
// Holds trap cause codes, next-PC select encoding and default vectors.
package pc_pkg;

  localparam logic [4:0] CAUSE_ADEL = 5'd4;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0040_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0040_0004;

  typedef enum logic [2:0] {
    SEQ,
    BR,
    JMP,
    JR,
    ERET,
    EXC
  } sel_e;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC source select and target computation.
// Folds a misaligned register jump into an address-error trap.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int             XLEN    = 32,
  parameter logic [XLEN-1:0] EXC_VEC = XLEN'(EXC_VEC_DEF)
) (
  input  logic [XLEN-1:0] pc_plus,
  input  logic [XLEN-1:0] epc,
  input  logic            exl,
  input  logic            br_taken,
  input  logic [15:0]     br_off,
  input  logic            jmp,
  input  logic [25:0]     jmp_idx,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_addr,
  input  logic            exc_req,
  input  logic [4:0]      exc_code,
  input  logic            eret,
  output sel_e            sel,
  output logic [XLEN-1:0] target,
  output logic [4:0]      exc_cause
);

  localparam int BW = (XLEN > 18) ? XLEN : 18;

  logic [BW-1:0]   br_sum;
  logic [BW-1:0]   br_ext;
  logic [XLEN-1:0] br_tgt;
  logic [XLEN-1:0] jmp_tgt;
  logic [27:0]     jmp_low;
  logic            misalign;

  assign misalign = (jr_addr[1:0] != 2'b00);
  assign jmp_low  = {jmp_idx, 2'b00};
  assign br_ext   = BW'($signed(br_off)) << 2;
  assign br_sum   = BW'(pc_plus) + br_ext;
  assign br_tgt   = br_sum[XLEN-1:0];

  if (XLEN > 28) begin : g_wide
    assign jmp_tgt = {pc_plus[XLEN-1:28], jmp_low};
  end else begin : g_narrow
    assign jmp_tgt = jmp_low[XLEN-1:0];
  end

  // Fixed-priority source select; misaligned jr becomes a trap
  always_comb begin
    sel       = SEQ;
    exc_cause = exc_code;
    if (exc_req) begin
      sel = EXC;
    end else if (eret) begin
      sel = exl ? ERET : SEQ;
    end else if (jr) begin
      if (misalign) begin
        sel       = EXC;
        exc_cause = CAUSE_ADEL;
      end else begin
        sel = JR;
      end
    end else if (jmp) begin
      sel = JMP;
    end else if (br_taken) begin
      sel = BR;
    end
  end

  // Target mux for the chosen source
  always_comb begin
    target = pc_plus;
    unique case (sel)
      SEQ:     target = pc_plus;
      BR:      target = br_tgt;
      JMP:     target = jmp_tgt;
      JR:      target = jr_addr;
      ERET:    target = epc;
      EXC:     target = EXC_VEC;
      default: target = pc_plus;
    endcase
  end

endmodule

// File: rtl/pc_unit.sv
// Program counter with branch/jump/jr, exception entry and return.
// All state advances on the falling clock edge when ena is high.
module pc_unit
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(RESET_VEC_DEF),
  parameter logic [XLEN-1:0] EXC_VEC   = XLEN'(EXC_VEC_DEF),
  parameter int              STEP      = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            br_taken,
  input  logic [15:0]     br_off,
  input  logic            jmp,
  input  logic [25:0]     jmp_idx,
  input  logic            jr,
  input  logic [XLEN-1:0] jr_addr,
  input  logic            exc_req,
  input  logic [4:0]      exc_code,
  input  logic            eret,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus,
  output logic [XLEN-1:0] epc,
  output logic [4:0]      cause,
  output logic            exl
);

  logic [XLEN-1:0] pc_d, pc_q;
  logic [XLEN-1:0] epc_d, epc_q;
  logic [4:0]      cause_d, cause_q;
  logic            exl_d, exl_q;

  sel_e            sel;
  logic [XLEN-1:0] target;
  logic [4:0]      exc_cause;

  assign pc_plus = pc_q + XLEN'(STEP);
  assign pc      = pc_q;
  assign epc     = epc_q;
  assign cause   = cause_q;
  assign exl     = exl_q;

  pc_next_sel #(
    .XLEN    (XLEN),
    .EXC_VEC (EXC_VEC)
  ) u_sel (
    .pc_plus   (pc_plus),
    .epc       (epc_q),
    .exl       (exl_q),
    .br_taken  (br_taken),
    .br_off    (br_off),
    .jmp       (jmp),
    .jmp_idx   (jmp_idx),
    .jr        (jr),
    .jr_addr   (jr_addr),
    .exc_req   (exc_req),
    .exc_code  (exc_code),
    .eret      (eret),
    .sel       (sel),
    .target    (target),
    .exc_cause (exc_cause)
  );

  // Next state: hold on stall, else follow the selected source
  always_comb begin
    pc_d    = pc_q;
    epc_d   = epc_q;
    cause_d = cause_q;
    exl_d   = exl_q;
    if (ena) begin
      pc_d = target;
      unique case (sel)
        EXC: begin
          cause_d = exc_cause;
          exl_d   = 1'b1;
          if (!exl_q) epc_d = pc_q;
        end
        ERET:    exl_d = 1'b0;
        default: ;
      endcase
    end
  end

  // State registers, falling-edge clocked, async active-low reset
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      epc_q   <= '0;
      cause_q <= '0;
      exl_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      epc_q   <= epc_d;
      cause_q <= cause_d;
      exl_q   <= exl_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: driver pushes model results,
// a negedge monitor pops and compares against the DUT.
module tb_pc_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        ena;
  logic        br_taken;
  logic [15:0] br_off;
  logic        jmp;
  logic [25:0] jmp_idx;
  logic        jr;
  logic [31:0] jr_addr;
  logic        exc_req;
  logic [4:0]  exc_code;
  logic        eret;
  logic [31:0] pc, pc_plus, epc;
  logic [4:0]  cause;
  logic        exl;

  logic        ena16;
  logic [15:0] pc16, pc_plus16, epc16;
  logic [4:0]  cause16;
  logic        exl16;

  pc_unit dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .br_taken (br_taken),
    .br_off   (br_off),
    .jmp      (jmp),
    .jmp_idx  (jmp_idx),
    .jr       (jr),
    .jr_addr  (jr_addr),
    .exc_req  (exc_req),
    .exc_code (exc_code),
    .eret     (eret),
    .pc       (pc),
    .pc_plus  (pc_plus),
    .epc      (epc),
    .cause    (cause),
    .exl      (exl)
  );

  pc_unit #(
    .XLEN      (16),
    .RESET_VEC (16'hFFFC),
    .EXC_VEC   (16'h0004),
    .STEP      (4)
  ) dut16 (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena16),
    .br_taken (1'b0),
    .br_off   (16'h0000),
    .jmp      (1'b0),
    .jmp_idx  (26'h0),
    .jr       (1'b0),
    .jr_addr  (16'h0000),
    .exc_req  (1'b0),
    .exc_code (5'd0),
    .eret     (1'b0),
    .pc       (pc16),
    .pc_plus  (pc_plus16),
    .epc      (epc16),
    .cause    (cause16),
    .exl      (exl16)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] pc_plus;
    logic [31:0] epc;
    logic [4:0]  cause;
    logic        exl;
  } exp_t;

  exp_t q[$];

  int tests = 0;
  int fails = 0;

  logic [31:0] m_pc, m_epc;
  logic [4:0]  m_cause;
  logic        m_exl;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc    = 32'h0040_0000;
    m_epc   = 32'h0;
    m_cause = 5'd0;
    m_exl   = 1'b0;
  endtask

  // Architectural model: priority chain over the request inputs
  task automatic model_step();
    logic [31:0] nxt;
    logic        trap;
    logic [4:0]  tcause;
    nxt    = m_pc + 32'd4;
    trap   = 1'b0;
    tcause = exc_code;
    if (!ena) return;
    if (exc_req) begin
      trap = 1'b1;
    end else if (eret) begin
      if (m_exl) begin
        nxt   = m_epc;
        m_exl = 1'b0;
      end
    end else if (jr) begin
      if (jr_addr % 4 != 0) begin
        trap   = 1'b1;
        tcause = 5'd4;
      end else begin
        nxt = jr_addr;
      end
    end else if (jmp) begin
      nxt = ((m_pc + 32'd4) & 32'hF000_0000) | (32'(jmp_idx) * 4);
    end else if (br_taken) begin
      nxt = (m_pc + 32'd4) + 32'(int'($signed(br_off)) * 4);
    end
    if (trap) begin
      if (!m_exl) m_epc = m_pc;
      m_exl   = 1'b1;
      m_cause = tcause;
      nxt     = 32'h0040_0004;
    end
    m_pc = nxt;
  endtask

  task automatic cyc(input logic en, input logic br,
                     input logic [15:0] off, input logic j,
                     input logic [25:0] idx, input logic r,
                     input logic [31:0] ra, input logic ex,
                     input logic [4:0] code, input logic er);
    exp_t e;
    @(posedge clk);
    #1;
    ena = en; br_taken = br; br_off = off;
    jmp = j; jmp_idx = idx; jr = r; jr_addr = ra;
    exc_req = ex; exc_code = code; eret = er;
    model_step();
    e.pc      = m_pc;
    e.pc_plus = m_pc + 32'd4;
    e.epc     = m_epc;
    e.cause   = m_cause;
    e.exl     = m_exl;
    q.push_back(e);
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input logic en);
    cyc(en, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 5'd0, 0);
  endtask

  // Monitor: compare DUT state to the oldest expectation after each edge
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sb_pc", pc, e.pc);
      chk("sb_pc_plus", pc_plus, e.pc_plus);
      chk("sb_epc", epc, e.epc);
      chk("sb_cause", 32'(cause), 32'(e.cause));
      chk("sb_exl", 32'(exl), 32'(e.exl));
    end
  end

  initial begin
    rst_n = 1'b0; ena = 1'b0; ena16 = 1'b0;
    br_taken = 0; br_off = '0; jmp = 0; jmp_idx = '0;
    jr = 0; jr_addr = '0; exc_req = 0; exc_code = '0; eret = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_epc", epc, 32'h0);
    chk("rst_cause", 32'(cause), 32'h0);
    chk("rst_exl", 32'(exl), 32'h0);
    chk("rst_pc16", 32'(pc16), 32'h0000_FFFC);
    chk("rst_pc_plus16", 32'(pc_plus16), 32'h0);

    @(negedge clk);
    #2;
    rst_n = 1'b1;
    ena16 = 1'b1;
    idle(1);
    chk("seq_pc1", pc, 32'h0040_0004);
    chk("wrap_pc16", 32'(pc16), 32'h0);
    ena16 = 1'b0;
    idle(1);
    chk("seq_pc2", pc, 32'h0040_0008);
    idle(0);
    chk("stall_pc", pc, 32'h0040_0008);
    idle(1);
    idle(1);
    chk("seq_pc4", pc, 32'h0040_0010);

    cyc(1, 1, 16'hFFFF, 0, 26'h0, 0, 32'h0, 0, 5'd0, 0);
    chk("br_back", pc, 32'h0040_0010);
    cyc(1, 1, 16'hFFFF, 1, 26'h010_0040, 0, 32'h0, 0, 5'd0, 0);
    chk("jmp_over_br", pc, 32'h0040_0100);

    cyc(1, 0, 16'h0, 0, 26'h0, 1, 32'h0040_0102, 0, 5'd0, 0);
    chk("adel_pc", pc, 32'h0040_0004);
    chk("adel_epc", epc, 32'h0040_0100);
    chk("adel_cause", 32'(cause), 32'd4);
    chk("adel_exl", 32'(exl), 32'd1);

    cyc(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 1, 5'd8, 0);
    chk("nest_pc", pc, 32'h0040_0004);
    chk("nest_cause", 32'(cause), 32'd8);
    chk("nest_epc", epc, 32'h0040_0100);

    cyc(1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 0, 5'd0, 1);
    chk("eret_pc", pc, 32'h0040_0100);
    chk("eret_exl", 32'(exl), 32'd0);

    repeat (3) cyc(0, 0, 16'h0, 1, 26'h3FF_FFFF, 0, 32'h0, 0, 5'd0, 0);
    chk("stall_jmp_pc", pc, 32'h0040_0100);

    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async_pc", pc, 32'h0040_0000);
    chk("rst_async_exl", 32'(exl), 32'd0);
    model_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b1;

    for (int i = 0; i < 400; i++) begin
      logic en, br, j, r, ex, er;
      logic [31:0] ra;
      en = ($urandom_range(0, 9) < 8);
      ex = ($urandom_range(0, 15) == 0);
      er = ($urandom_range(0, 7) == 0);
      r  = ($urandom_range(0, 7) == 0);
      j  = ($urandom_range(0, 7) == 0);
      br = ($urandom_range(0, 3) == 0);
      ra = $urandom;
      if ($urandom_range(0, 7) != 0) ra[1:0] = 2'b00;
      if (er) begin
        r = 0; j = 0; br = 0;
      end
      cyc(en, br, 16'($urandom), j, 26'($urandom), r, ra,
          ex, 5'($urandom), er);
    end

    @(negedge clk);
    #3;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
